alarm_sequencer: RTL
====================

# alarm_sequencer

Controls the alarm's music player. It watches the current time against the programmed alarm time and starts the alarm when they match. It then sequences the ringing, snooze, stop and timeout behaviour, and drives the `alarm`, `sel` and song-restart inputs of the music player. It sits between the timekeeping/user-input logic and the music player, and is the only block that drives `alarm`.

## Interface
- `SNOOZE_SEC`, default 300: snooze length in seconds (at least 1).
- `RING_TIMEOUT_SEC`, default 600: maximum continuous ring time in seconds (at least 1).
- `MAX_SNOOZES`, default 3: snoozes allowed per alarm event (0–15).

Ports (clock and reset first):
- `clk`, in, 1: system clock (25 MHz). The block uses one clock.
- `rst`, in, 1: reset. Synchronous and active-high.
- `tick_1hz`, in, 1: single-cycle pulse, once per second.
- `cur_hh`, in, 5: current hour, binary 0–23.
- `cur_mm`, in, 6: current minute, binary 0–59.
- `alm_hh`, in, 5: alarm hour, binary.
- `alm_mm`, in, 6: alarm minute, binary.
- `alarm_en`, in, 1: alarm armed; level input.
- `snooze_btn`, in, 1: single-cycle pulse, already debounced upstream.
- `stop_btn`, in, 1: single-cycle pulse, already debounced upstream.
- `song_cfg`, in, 2: song choice, passed to the music player's `sel`.
- `alarm`, out, 1: enables the music player.
- `sel`, out, 2: song select for the music player.
- `song_restart`, out, 1: single-cycle pulse that resets the music player's tone counter.
- `state`, out, 2: state code. IDLE=0, RINGING=1, SNOOZE=2, DONE=3.
- `snooze_count`, out, 4: number of snoozes used in the current event.

## Operation
- Match condition: `match = alarm_en && cur_hh==alm_hh && cur_mm==alm_mm`.
- IDLE: when `match` is 1, go to RINGING. Latch `song_cfg` into `sel`, clear the ring timer and `snooze_count`, and pulse `song_restart`.
- RINGING: `alarm` is 1. The ring timer increments on each `tick_1hz`. Transitions are evaluated in priority order, highest first:
  1. `alarm_en`=0: go to IDLE.
  2. `stop_btn`: go to DONE.
  3. `snooze_btn` with `snooze_count`<`MAX_SNOOZES`: go to SNOOZE, increment `snooze_count`, load the snooze timer with `SNOOZE_SEC`.
  4. `tick_1hz` with ring timer == `RING_TIMEOUT_SEC`-1: go to DONE (timeout).
- RINGING, snooze limit: `snooze_btn` with `snooze_count`==`MAX_SNOOZES` is ignored and ringing continues.
- SNOOZE: `alarm` is 0. The snooze timer decrements on each `tick_1hz`. Transitions in priority order:
  1. `alarm_en`=0: go to IDLE.
  2. `stop_btn`: go to DONE.
  3. `tick_1hz` with snooze timer==1: go to RINGING, clear the ring timer, pulse `song_restart`. `sel` is kept (not re-latched).
  4. `snooze_btn` in SNOOZE is ignored.
- DONE: `alarm` is 0. Go to IDLE when `match` is 0, or when `alarm_en` is 0. This prevents a second trigger within the same alarm minute.
- Effects of returning to IDLE:
  - Timers are cleared.
  - `snooze_count` holds its value until the next trigger.
  - `sel` holds its value.
- Re-arming `alarm_en` within the alarm minute after an IDLE exit triggers the alarm again. This is intended behaviour.
- Counter widths: `$clog2(PARAM+1)`. Counters saturate and never wrap. A `tick_1hz` arriving in IDLE or DONE has no effect.

## Timing
- Reset values:
  - `state`=IDLE, `alarm`=0, `sel`=2'b00, `song_restart`=0, `snooze_count`=0.
  - All timers 0.
  - Reset takes priority over every other input on the same edge, including mid-ring.
- `alarm` is decoded from the registered `state` (`state`==RINGING). It rises on the first clock edge at which `match` is sampled as 1, so it is high in the following cycle (1-cycle latency).
- `song_restart` is registered and high for exactly the one cycle in which `state` first reads RINGING.
- A button pulse takes effect on the edge at which it is sampled. `alarm` falls in the next cycle.
- The timeout state change occurs on the edge that samples the `RING_TIMEOUT_SEC`-th tick after entry to RINGING. The snooze return occurs on the edge that samples the `SNOOZE_SEC`-th tick after entry to SNOOZE.
- Simultaneous events follow the priority lists above. For example, `stop_btn` together with the snooze-expiry tick gives DONE.

## Test plan
All scenarios use `SNOOZE_SEC`=3, `RING_TIMEOUT_SEC`=5, `MAX_SNOOZES`=2.
- Basic trigger: `alm`=07:30, `cur` changes to 07:30 with `alarm_en`=1 and `song_cfg`=2'b10. Required: `alarm`=1 one cycle later, `sel`=2'b10, `song_restart` high for exactly 1 cycle, `state`=1.
- Timeout: trigger, then 5 ticks with no buttons. Required: `state`=3 and `alarm`=0 after the 5th tick; no retrigger while `cur` stays at 07:30; `state`=0 when `cur` becomes 07:31.
- Snooze cycle: trigger, pulse snooze. Required: `state`=2, `alarm`=0, `snooze_count`=1. After 3 ticks: `state`=1, `alarm`=1, `song_restart` pulses. Snooze twice more: the 3rd press is ignored, `snooze_count` stays 2, ringing continues.
- Stop during snooze: `stop_btn` in the same cycle as the 3rd snooze tick. Required: `state`=3 and `alarm` stays 0.
- Disarm: drop `alarm_en` during RINGING. Required: `state`=0 next cycle, `alarm`=0.
- Reset mid-ring: assert `rst` while RINGING. Required: all outputs at their reset values next cycle, including `sel`=2'b00.

Source files
------------

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: detects the programmed alarm minute and sequences ringing, snooze,
// stop and timeout for the music player it drives.
module alarm_sequencer #(
  parameter int unsigned SNOOZE_SEC       = 300,
  parameter int unsigned RING_TIMEOUT_SEC = 600,
  parameter int unsigned MAX_SNOOZES      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [4:0] cur_hh,
  input  logic [5:0] cur_mm,
  input  logic [4:0] alm_hh,
  input  logic [5:0] alm_mm,
  input  logic       alarm_en,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  input  logic [1:0] song_cfg,
  output logic       alarm,
  output logic [1:0] sel,
  output logic       song_restart,
  output logic [1:0] state,
  output logic [3:0] snooze_count
);

  localparam int unsigned RingW = $clog2(RING_TIMEOUT_SEC + 1);
  localparam int unsigned SnzW  = $clog2(SNOOZE_SEC + 1);

  localparam logic [RingW-1:0] RingLast = RingW'(RING_TIMEOUT_SEC - 1);
  localparam logic [RingW-1:0] RingMax  = RingW'(RING_TIMEOUT_SEC);
  localparam logic [SnzW-1:0]  SnzLoad  = SnzW'(SNOOZE_SEC);
  localparam logic [3:0]       SnzLimit = 4'(MAX_SNOOZES);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRinging = 2'd1,
    StSnooze  = 2'd2,
    StDone    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [RingW-1:0] ring_q, ring_d;
  logic [SnzW-1:0]  snz_q, snz_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             restart_q, restart_d;
  logic             match;

  assign match = alarm_en && (cur_hh == alm_hh) && (cur_mm == alm_mm);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (match) state_d = StRinging;
      end
      StRinging: begin
        if (!alarm_en)                                state_d = StIdle;
        else if (stop_btn)                            state_d = StDone;
        else if (snooze_btn && (cnt_q < SnzLimit))    state_d = StSnooze;
        else if (tick_1hz && (ring_q == RingLast))    state_d = StDone;
      end
      StSnooze: begin
        if (!alarm_en)                                state_d = StIdle;
        else if (stop_btn)                            state_d = StDone;
        else if (tick_1hz && (snz_q == SnzW'(1)))     state_d = StRinging;
      end
      StDone: begin
        // Holding here until the minute passes blocks a second trigger.
        if (!match) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    alarm        = (state_q == StRinging);
    state        = 2'(state_q);
    sel          = sel_q;
    song_restart = restart_q;
    snooze_count = cnt_q;
  end

  // Timers run only while staying in their own state; any other path clears them.
  always_comb begin
    ring_d    = '0;
    snz_d     = '0;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    restart_d = (state_d == StRinging) && (state_q != StRinging);

    if ((state_q == StIdle) && (state_d == StRinging)) begin
      sel_d = song_cfg;
      cnt_d = '0;
    end

    if ((state_q == StRinging) && (state_d == StRinging)) begin
      ring_d = ring_q;
      if (tick_1hz && (ring_q != RingMax)) ring_d = ring_q + RingW'(1);
    end

    if ((state_q == StRinging) && (state_d == StSnooze)) begin
      snz_d = SnzLoad;
      if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
    end

    if ((state_q == StSnooze) && (state_d == StSnooze)) begin
      snz_d = snz_q;
      if (tick_1hz && (snz_q != '0)) snz_d = snz_q - SnzW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_q    <= '0;
      snz_q     <= '0;
      cnt_q     <= '0;
      sel_q     <= 2'b00;
      restart_q <= 1'b0;
    end else begin
      ring_q    <= ring_d;
      snz_q     <= snz_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      restart_q <= restart_d;
    end
  end

endmodule
